// File: rtl/cache_req_arb_if.sv
// Purpose: request/queue-write bundle between cache requesters, the arbiter and the instruction queue.
// Latency: n/a (wires only); payload fields are packed per requester, slice i = requester i.
// Backpressure: q_full/q_valid flow from the queue into the arbiter; gnt returns to requesters.
//
// Signals:
//   req, addr_in, operation_in, is_flush_in, dest_in : requester side, driven by requesters
//   q_full, q_valid                                  : queue status, driven by the queue
//   gnt, alloc, *_out, drain_busy                    : driven by the arbiter
// Modports: slave = arbiter view, master = requester/queue (environment) view.

interface cache_req_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int N_REQ      = 4
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*ADDR_WIDTH-1:0] addr_in;
    logic [N_REQ*3-1:0]          operation_in;
    logic [N_REQ-1:0]            is_flush_in;
    logic [N_REQ*2-1:0]          dest_in;
    logic                        q_full;
    logic                        q_valid;

    logic [N_REQ-1:0]            gnt;
    logic                        alloc;
    logic [ADDR_WIDTH-1:0]       addr_out;
    logic [2:0]                  operation_out;
    logic                        is_flush_out;
    logic [1:0]                  src_out;
    logic [1:0]                  dest_out;
    logic                        drain_busy;

    modport slave (
        input  req, addr_in, operation_in, is_flush_in, dest_in, q_full, q_valid,
        output gnt, alloc, addr_out, operation_out, is_flush_out, src_out, dest_out,
               drain_busy
    );

    modport master (
        output req, addr_in, operation_in, is_flush_in, dest_in, q_full, q_valid,
        input  gnt, alloc, addr_out, operation_out, is_flush_out, src_out, dest_out,
               drain_busy
    );
endinterface

// File: rtl/cache_req_arb.sv
// Purpose: round-robin arbiter picking one of 4 cache requesters per cycle and writing its entry into the instruction queue.
// Latency: 0 cycles -- grant, alloc and payload are combinational from req/payload in the same cycle; no payload storage.
// Backpressure: q_full suppresses grants (requesters hold); a granted flush parks the arbiter in DRAIN until q_valid drops.
//
// Ports: clk, rst (synchronous, active-high); bus = cache_req_arb_if.slave (requester inputs, queue status,
//        grant/alloc/payload outputs, drain_busy).
// Build option: define ARB_FLUSH_PRIO_EN to make flush requests win over non-flush requests
//               (round-robin among the flush requesters). Undefined: all requesters are equal.

module cache_req_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int N_REQ      = 4      // src_out is 2 bits, so this must stay 4
) (
    input  logic             clk,
    input  logic             rst,
    cache_req_arb_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0] eligible;
    logic [1:0]       win;
    logic [1:0]       scan_idx;
    logic             win_found;
    logic             grant_ok;

    logic [ADDR_WIDTH-1:0] win_addr;
    logic [2:0]            win_op;
    logic                  win_flush;
    logic [1:0]            win_dest;

    // ------------------------------------------------------------------
    // Eligibility: with flush priority, a pending flush masks out every
    // non-flush requester so the flush reaches the queue first.
    // ------------------------------------------------------------------
`ifdef ARB_FLUSH_PRIO_EN
    logic [N_REQ-1:0] flush_req;

    always_comb begin
        flush_req = bus.req & bus.is_flush_in;
        if (flush_req != '0) begin
            eligible = flush_req;
        end else begin
            eligible = bus.req;
        end
    end
`else
    always_comb begin
        eligible = bus.req;
    end
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible requester scanning up from rr_ptr.
    // The 2-bit index add wraps 3 -> 0 naturally.
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win       = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win       = scan_idx;
            end
        end
    end

    // Grants happen only in ARB with queue space; reset forces everything quiet.
    always_comb begin
        grant_ok = (state_q == ST_ARB) && !bus.q_full && win_found && !rst;
    end

    // Winner's payload, selected straight from the requester buses.
    always_comb begin
        win_addr  = bus.addr_in[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        win_op    = bus.operation_in[int'(win)*3 +: 3];
        win_flush = bus.is_flush_in[win];
        win_dest  = bus.dest_in[int'(win)*2 +: 2];
    end

    // ------------------------------------------------------------------
    // Next-state / pointer logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_ARB: begin
                if (grant_ok) begin
                    rr_ptr_d = win + 2'd1;
                    if (win_flush) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once the queue has emptied; the first new grant is the following cycle.
                if (!bus.q_valid) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: payload is forced to zero whenever no entry is written so
    // the queue never sees stale winner data.
    // ------------------------------------------------------------------
    always_comb begin
        bus.gnt           = '0;
        bus.alloc         = 1'b0;
        bus.addr_out      = '0;
        bus.operation_out = 3'd0;
        bus.is_flush_out  = 1'b0;
        bus.src_out       = 2'd0;
        bus.dest_out      = 2'd0;
        if (grant_ok) begin
            bus.gnt[win]      = 1'b1;
            bus.alloc         = 1'b1;
            bus.addr_out      = win_addr;
            bus.operation_out = win_op;
            bus.is_flush_out  = win_flush;
            bus.src_out       = win;
            bus.dest_out      = win_dest;
        end
    end

    always_comb begin
        bus.drain_busy = (state_q == ST_DRAIN) && !rst;
    end

    // ------------------------------------------------------------------
    // Structural invariants.
    // ------------------------------------------------------------------
    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(bus.gnt));
    a_alloc_gnt:   assert property (@(posedge clk) bus.alloc == (bus.gnt != '0));
    a_drain_quiet: assert property (@(posedge clk) (state_q == ST_DRAIN) |-> (bus.gnt == '0));

endmodule

// File: tb/tb_cache_req_arb.sv
// Purpose: directed scoreboard bench for cache_req_arb (round-robin, q_full stall, flush/drain, reset, flush priority).
// Latency: stimulus is applied 1 time unit after a rising edge; the monitor checks the same cycle at the falling edge.
// Backpressure: q_full/q_valid are driven directly by the directed vectors.

module tb_cache_req_arb;

    localparam int AW = 32;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        alloc;
        logic [31:0] addr;
        logic [2:0]  op;
        logic        flush;
        logic [1:0]  src;
        logic [1:0]  dest;
        logic        busy;
    } exp_t;

    logic clk;
    logic rst;

    cache_req_arb_if #(.ADDR_WIDTH(AW), .N_REQ(4)) bus ();

    cache_req_arb #(.ADDR_WIDTH(AW), .N_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    vec_cnt = 0;
    int    miscompares = 0;

    // Fixed per-requester payload; requester 2 carries the 0x1000 / 3'b101 entry.
    function automatic logic [31:0] addr_of(input logic [1:0] i);
        case (i)
            2'd0:    return 32'h0000_0A00;
            2'd1:    return 32'h0000_0B40;
            2'd2:    return 32'h0000_1000;
            default: return 32'hDEAD_0C00;
        endcase
    endfunction

    function automatic logic [2:0] op_of(input logic [1:0] i);
        case (i)
            2'd0:    return 3'b011;
            2'd1:    return 3'b110;
            2'd2:    return 3'b101;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [1:0] dest_of(input logic [1:0] i);
        case (i)
            2'd0:    return 2'd2;
            2'd1:    return 2'd3;
            2'd2:    return 2'd1;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Apply one cycle of stimulus and queue the hand-computed response for it.
    // eg = expected one-hot grant (0 = no write), eb = expected drain_busy.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] fl,
                        input logic qf, input logic qv, input logic [3:0] eg,
                        input logic eb, input string nm);
        exp_t e;
        logic [1:0] s;
        @(posedge clk);
        #1;
        rst             = r;
        bus.req         = rq;
        bus.is_flush_in = fl;
        bus.q_full      = qf;
        bus.q_valid     = qv;
        s       = idx_of(eg);
        e       = '0;
        e.gnt   = eg;
        e.busy  = eb;
        if (eg != 4'b0000) begin
            e.alloc = 1'b1;
            e.addr  = addr_of(s);
            e.op    = op_of(s);
            e.flush = fl[s];
            e.src   = s;
            e.dest  = dest_of(s);
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: pops one expectation for every cycle the stimulus queued one.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                vec_cnt++;
                if (bus.gnt !== e.gnt || bus.alloc !== e.alloc || bus.addr_out !== e.addr ||
                    bus.operation_out !== e.op || bus.is_flush_out !== e.flush ||
                    bus.src_out !== e.src || bus.dest_out !== e.dest ||
                    bus.drain_busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s: got gnt=%b alloc=%b addr=%h op=%b fl=%b src=%0d dest=%0d busy=%b; want gnt=%b alloc=%b addr=%h op=%b fl=%b src=%0d dest=%0d busy=%b",
                             nm, bus.gnt, bus.alloc, bus.addr_out, bus.operation_out,
                             bus.is_flush_out, bus.src_out, bus.dest_out, bus.drain_busy,
                             e.gnt, e.alloc, e.addr, e.op, e.flush, e.src, e.dest, e.busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.req          = 4'b0000;
        bus.is_flush_in  = 4'b0000;
        bus.q_full       = 1'b0;
        bus.q_valid      = 1'b0;
        bus.addr_in      = {addr_of(2'd3), addr_of(2'd2), addr_of(2'd1), addr_of(2'd0)};
        bus.operation_in = {op_of(2'd3), op_of(2'd2), op_of(2'd1), op_of(2'd0)};
        bus.dest_in      = {dest_of(2'd3), dest_of(2'd2), dest_of(2'd1), dest_of(2'd0)};

        // Reset holds every output low even with all requests up.
        step(1, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, "rst_quiet_0");
        step(1, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, "rst_quiet_1");

        // Full rotation from rr_ptr=0.
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b0001, 0, "rr_0");
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b0010, 0, "rr_1");
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b0100, 0, "rr_2");
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b1000, 0, "rr_3");
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b0001, 0, "rr_wrap");
        step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, "idle_no_req");

        // q_full stall, pointer must not move while stalled.
        step(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, "rst_b");
        step(0, 4'b0101, 4'b0000, 1, 0, 4'b0000, 0, "full_0");
        step(0, 4'b0101, 4'b0000, 1, 0, 4'b0000, 0, "full_1");
        step(0, 4'b0101, 4'b0000, 1, 0, 4'b0000, 0, "full_2");
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0001, 0, "full_release_0");
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0100, 0, "full_release_1");

        // Flush from requester 2, then drain while q_valid stays high.
        step(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, "rst_c");
        step(0, 4'b0100, 4'b0100, 0, 1, 4'b0100, 0, "flush_grant");
        step(0, 4'b1111, 4'b0000, 0, 1, 4'b0000, 1, "drain_0");
        step(0, 4'b1111, 4'b0000, 1, 1, 4'b0000, 1, "drain_full");
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, "drain_qv_low");
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b1000, 0, "drain_exit_grant");
        step(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 0, "ptr_to_3");
        step(0, 4'b0011, 4'b0000, 0, 0, 4'b0001, 0, "wrap_3_to_0");

        // Reset arriving mid-DRAIN.
        step(0, 4'b0010, 4'b0010, 0, 1, 4'b0010, 0, "flush_grant_1");
        step(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 1, "drain_b");
        step(1, 4'b1111, 4'b0000, 0, 1, 4'b0000, 0, "rst_in_drain");
        step(0, 4'b1010, 4'b0000, 0, 1, 4'b0010, 0, "post_rst_ptr0");
        step(0, 4'b1000, 4'b0000, 0, 1, 4'b1000, 0, "post_rst_req3");

        // Flush priority against a lower-index non-flush requester.
        step(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, "rst_d");
`ifdef ARB_FLUSH_PRIO_EN
        step(0, 4'b0011, 4'b0010, 0, 0, 4'b0010, 0, "flush_prio");
        step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, "flush_prio_drain");
`else
        step(0, 4'b0011, 4'b0010, 0, 0, 4'b0001, 0, "flush_no_prio");
        step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, "flush_no_prio_idle");
`endif
        step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, "final_idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_scoreboard: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
